// File: rtl/ship_pkg.sv
// Shared screen constants and motion controller state encoding for the spaceship
// display path (ship_motion_ctrl, sprite renderer).
package ship_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int SCREEN_CORDW = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    MOVE
  } state_t;

endpackage

// File: rtl/ship_motion_ctrl_tilt_filter.sv
// 4-tap moving average over accepted tilt samples; avg is combinational from the
// registered taps, so a sample is visible one cycle after its strobe.
module tilt_filter #(
  parameter int TILT_W = 16
) (
  input  logic                     clk_pix,
  input  logic                     rst,
  input  logic                     tilt_valid,
  input  logic signed [TILT_W-1:0] tilt_x,
  output logic signed [TILT_W-1:0] avg,
  output logic                     avg_valid
);

  logic signed [TILT_W-1:0] taps [4];
  logic signed [TILT_W+1:0] sum;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) taps[i] <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= tilt_valid;
      if (tilt_valid) begin
        taps[0] <= tilt_x;
        for (int i = 1; i < 4; i++) taps[i] <= taps[i-1];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) sum = sum + (TILT_W+2)'(taps[i]);
  end

  // Sum of four taps divided by four always fits back into TILT_W bits.
  assign avg = TILT_W'(sum >>> 2);

endmodule

// File: rtl/ship_motion_ctrl.sv
// Tilt-driven spaceship X position: filtered, speed-limited, edge-clamped, one update per frame.
// Optional deadzone compiled in with SHIP_MOTION_DEADZONE_EN.
//
// state | meaning
// IDLE  | waiting for an enabled frame pulse
// CALC  | latch saturated velocity from the filtered tilt
// MOVE  | apply velocity to sprite_x with wall clamping, pulse pos_update
module ship_motion_ctrl
  import ship_pkg::state_t, ship_pkg::IDLE, ship_pkg::CALC, ship_pkg::MOVE;
#(
  parameter int H_RES        = ship_pkg::H_RES,
  parameter int SCREEN_CORDW = ship_pkg::SCREEN_CORDW,
  parameter int SHIP_PIX_W   = 34,
  parameter int SHIP_Y       = 300,
  parameter int TILT_W       = 16,
  parameter int TILT_SHIFT   = 5,
  parameter int MAX_SPEED    = 8,
  parameter int DEADZONE     = 2
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    frame,
  input  logic                    tilt_valid,
  input  logic signed [TILT_W-1:0] tilt_x,
  output logic [SCREEN_CORDW-1:0] sprite_x,
  output logic [SCREEN_CORDW-1:0] sprite_y,
  output logic signed [7:0]       velocity,
  output logic                    pos_update
);

  localparam logic signed [TILT_W-1:0]     MAX_V = TILT_W'(MAX_SPEED);
  localparam logic signed [SCREEN_CORDW:0] X_MAX = (SCREEN_CORDW+1)'(H_RES - SHIP_PIX_W);
  localparam logic [SCREEN_CORDW-1:0]      X_RST = SCREEN_CORDW'((H_RES - SHIP_PIX_W) / 2);

  state_t state, state_next;
  logic   load_vel, load_pos;

  logic signed [TILT_W-1:0]       avg, v_raw, v_sat, v_fin;
  logic signed [7:0]              vel_next;
  logic signed [SCREEN_CORDW:0]   nx;
  logic [SCREEN_CORDW-1:0]        x_next;
  logic                           unused_avg_valid;

  tilt_filter #(.TILT_W(TILT_W)) u_filter (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .tilt_valid (tilt_valid),
    .tilt_x     (tilt_x),
    .avg        (avg),
    .avg_valid  (unused_avg_valid)
  );

  always_comb begin
    v_raw = avg >>> TILT_SHIFT;
    if (v_raw > MAX_V)       v_sat = MAX_V;
    else if (v_raw < -MAX_V) v_sat = -MAX_V;
    else                     v_sat = v_raw;
`ifdef SHIP_MOTION_DEADZONE_EN
    // A level board still reports small noise; do not let it creep the ship.
    if (v_sat <= TILT_W'(DEADZONE) && v_sat >= -TILT_W'(DEADZONE)) v_fin = '0;
    else                                                          v_fin = v_sat;
`else
    v_fin = v_sat;
`endif
    vel_next = 8'(v_fin);
  end

  always_comb begin
    nx = $signed({1'b0, sprite_x}) + (SCREEN_CORDW+1)'(velocity);
    if (nx < 0)          x_next = '0;
    else if (nx > X_MAX) x_next = X_MAX[SCREEN_CORDW-1:0];
    else                 x_next = nx[SCREEN_CORDW-1:0];
  end

  always_comb begin
    state_next = state;
    load_vel   = 1'b0;
    load_pos   = 1'b0;
    case (state)
      IDLE: if (frame && en) state_next = CALC;
      CALC: begin
        load_vel   = 1'b1;
        state_next = MOVE;
      end
      MOVE: begin
        load_pos   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state      <= IDLE;
      sprite_x   <= X_RST;
      velocity   <= '0;
      pos_update <= 1'b0;
    end else begin
      state      <= state_next;
      pos_update <= load_pos;
      if (load_vel) velocity <= vel_next;
      if (load_pos) sprite_x <= x_next;
    end
  end

  assign sprite_y = SCREEN_CORDW'(SHIP_Y);

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Self-checking bench for ship_motion_ctrl: vector table, corner sequences and
// randomized traffic against a frame-level behavioural model.
module tb_ship_motion_ctrl;

  localparam int X_MAX = 606;
  localparam int X_RST = 303;

  logic               clk_pix = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               frame = 1'b0;
  logic               tilt_valid = 1'b0;
  logic signed [15:0] tilt_x = '0;
  logic [15:0]        sprite_x, sprite_y;
  logic signed [7:0]  velocity;
  logic               pos_update;

  ship_motion_ctrl dut (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .en         (en),
    .frame      (frame),
    .tilt_valid (tilt_valid),
    .tilt_x     (tilt_x),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .velocity   (velocity),
    .pos_update (pos_update)
  );

  always #20 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;
  string tag = "init";

  // Behavioural model: last four samples, position, velocity, pending frame update.
  int m_taps[4];
  int m_x, m_vel, m_pu, busy, pend_vel, pend_x;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0d expected=%0d", tag, name, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_vel();
    int s, v;
    s = m_taps[0] + m_taps[1] + m_taps[2] + m_taps[3];
    v = fdiv(fdiv(s, 4), 32);
    if (v > 8)  v = 8;
    if (v < -8) v = -8;
`ifdef SHIP_MOTION_DEADZONE_EN
    if (v >= -2 && v <= 2) v = 0;
`endif
    return v;
  endfunction

  task automatic model_edge(input bit f, input bit e, input bit tv, input int tx, input bit r);
    bit start;
    if (r) begin
      for (int i = 0; i < 4; i++) m_taps[i] = 0;
      m_x = X_RST; m_vel = 0; m_pu = 0; busy = 0;
      return;
    end
    start = 0;
    m_pu  = 0;
    if (busy == 1) begin
      m_x = pend_x; m_pu = 1; busy = 0;
    end else if (busy == 2) begin
      m_vel = pend_vel; busy = 1;
    end else if (f && e) begin
      busy = 2; start = 1;
    end
    if (tv) begin
      for (int i = 3; i > 0; i--) m_taps[i] = m_taps[i-1];
      m_taps[0] = tx;
    end
    if (start) begin
      pend_vel = model_vel();
      pend_x   = m_x + pend_vel;
      if (pend_x < 0)     pend_x = 0;
      if (pend_x > X_MAX) pend_x = X_MAX;
    end
  endtask

  task automatic cycle(input bit f, input bit e, input bit tv, input int tx, input bit r);
    frame = f; en = e; tilt_valid = tv; tilt_x = 16'(tx); rst = r;
    @(posedge clk_pix);
    model_edge(f, e, tv, tx, r);
    #1;
    frame = 0; tilt_valid = 0; rst = 0;
    check("model_x", int'(sprite_x), m_x);
    check("model_vel", int'(velocity), m_vel);
    check("model_pu", int'(pos_update), m_pu);
  endtask

  typedef struct {
    int tilt;
    int nsamp;
    bit en;
    int exp_vel;
    int exp_x;
    bit exp_pu;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1024, 4, 1'b1, 8, 311, 1'b1};
    vecs[1]  = '{-1024, 4, 1'b1, -8, 295, 1'b1};
    vecs[2]  = '{100, 4, 1'b1, 3, 306, 1'b1};
    vecs[3]  = '{-65, 4, 1'b1, -3, 300, 1'b1};
    vecs[4]  = '{0, 4, 1'b1, 0, 303, 1'b1};
    vecs[5]  = '{1024, 1, 1'b1, 8, 311, 1'b1};
    vecs[6]  = '{200, 2, 1'b1, 3, 306, 1'b1};
    vecs[7]  = '{1024, 4, 1'b0, 0, 303, 1'b0};
`ifdef SHIP_MOTION_DEADZONE_EN
    vecs[8]  = '{64, 4, 1'b1, 0, 303, 1'b1};
    vecs[9]  = '{-64, 4, 1'b1, 0, 303, 1'b1};
    vecs[10] = '{-1, 4, 1'b1, 0, 303, 1'b1};
`else
    vecs[8]  = '{64, 4, 1'b1, 2, 305, 1'b1};
    vecs[9]  = '{-64, 4, 1'b1, -2, 301, 1'b1};
    vecs[10] = '{-1, 4, 1'b1, -1, 302, 1'b1};
`endif

    tag = "reset";
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    check("x", int'(sprite_x), 303);
    check("y", int'(sprite_y), 300);
    check("vel", int'(velocity), 0);
    check("pu", int'(pos_update), 0);

    tag = "idle_frame";
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("vel", int'(velocity), 0);
    cycle(0, 1, 0, 0, 0);
    check("x", int'(sprite_x), 303);
    check("pu", int'(pos_update), 1);
    cycle(0, 1, 0, 0, 0);
    check("pu_drop", int'(pos_update), 0);

    for (int k = 0; k < 11; k++) begin
      tag = $sformatf("vec%0d", k);
      cycle(0, 1, 0, 0, 1);
      for (int s = 0; s < vecs[k].nsamp; s++) cycle(0, 1, 1, vecs[k].tilt, 0);
      cycle(1, vecs[k].en, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      check("vel", int'(velocity), vecs[k].exp_vel);
      cycle(0, 1, 0, 0, 0);
      check("x", int'(sprite_x), vecs[k].exp_x);
      check("pu", int'(pos_update), int'(vecs[k].exp_pu));
      cycle(0, 1, 0, 0, 0);
      check("pu_drop", int'(pos_update), 0);
    end

    tag = "left_wall";
    cycle(0, 1, 0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      int ex;
      cycle(1, 1, 1, -4096, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      ex = 303 - 8 * (k + 1);
      if (ex < 0) ex = 0;
      check("x", int'(sprite_x), ex);
    end
    check("x_final", int'(sprite_x), 0);

    tag = "right_wall";
    cycle(0, 1, 0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      int ex;
      cycle(1, 1, 1, 4096, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      ex = 303 + 8 * (k + 1);
      if (ex > 606) ex = 606;
      check("x", int'(sprite_x), ex);
    end
    check("x_final", int'(sprite_x), 606);

    tag = "simul_1024";
    cycle(0, 1, 0, 0, 1);
    for (int s = 0; s < 3; s++) cycle(0, 1, 1, 1024, 0);
    cycle(1, 1, 1, 1024, 0);
    cycle(0, 1, 0, 0, 0);
    check("vel", int'(velocity), 8);

    tag = "simul_zero";
    cycle(0, 1, 0, 0, 1);
    for (int s = 0; s < 3; s++) cycle(0, 1, 1, 1024, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("vel", int'(velocity), 8);

    tag = "simul_only";
    cycle(0, 1, 0, 0, 1);
    cycle(1, 1, 1, 1024, 0);
    cycle(0, 1, 0, 0, 0);
    check("vel", int'(velocity), 8);
    cycle(0, 1, 0, 0, 0);
    check("x", int'(sprite_x), 311);

    tag = "busy_frame";
    cycle(0, 1, 0, 0, 1);
    cycle(1, 1, 1, 1024, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("x", int'(sprite_x), 311);
    cycle(0, 1, 0, 0, 0);
    check("pu_drop", int'(pos_update), 0);
    check("x_hold", int'(sprite_x), 311);

    tag = "mid_reset";
    cycle(0, 1, 0, 0, 1);
    for (int s = 0; s < 4; s++) cycle(0, 1, 1, 1024, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    check("x", int'(sprite_x), 303);
    check("pu", int'(pos_update), 0);
    cycle(0, 1, 0, 0, 0);
    check("pu_after", int'(pos_update), 0);
    cycle(0, 1, 0, 0, 0);
    check("pu_after2", int'(pos_update), 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("vel_cleared", int'(velocity), 0);
    cycle(0, 1, 0, 0, 0);
    check("x_cleared", int'(sprite_x), 303);

    tag = "random";
    cycle(0, 1, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      bit r, f, e, tv;
      int tx;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 4) != 0);
      tv = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) tx = int'($urandom_range(0, 400)) - 200;
      else                           tx = int'($signed(16'($urandom)));
      cycle(f, e, tv, tx, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_motion_ctrl.md
# ship_motion_ctrl

Converts accelerometer tilt samples into the spaceship's on-screen position once per video frame. It replaces the push-button/switch stepping logic with a filtered, speed-limited, edge-clamped motion controller. It sits directly upstream of the spaceship sprite renderer: its `sprite_x`/`sprite_y` outputs drive that renderer's `sprite_x`/`sprite_y` inputs. It also feeds the 7-segment coordinate display.

## Interface
Parameters:
- `H_RES`, 640: horizontal screen resolution in pixels.
- `SCREEN_CORDW`, 16: width of screen coordinates.
- `SHIP_PIX_W`, 34: on-screen ship width (sprite width 17 × scale 2).
- `SHIP_Y`, 300: fixed vertical ship position.
- `TILT_W`, 16: width of the signed tilt sample.
- `TILT_SHIFT`, 5: right-shift converting averaged tilt to pixels/frame.
- `MAX_SPEED`, 8: velocity magnitude limit, in pixels/frame.
- `DEADZONE`, 2: velocity magnitude forced to 0 (only when the deadzone is compiled in).

Ports:
- `clk_pix`, in, 1: 25 MHz pixel clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: motion enable; 0 freezes the position (pause).
- `frame`, in, 1: one-cycle pulse at frame start, from the display timing generator.
- `tilt_valid`, in, 1: tilt sample strobe, already synchronous to `clk_pix`.
- `tilt_x`, in, TILT_W (signed): X-axis tilt; positive moves the ship right.
- `sprite_x`, out, SCREEN_CORDW: ship left edge.
- `sprite_y`, out, SCREEN_CORDW: ship top edge.
- `velocity`, out, 8 (signed): velocity applied at the last update.
- `pos_update`, out, 1: one-cycle pulse when `sprite_x` has just been written.

## Operation
Reset values:
- `sprite_x` = (H_RES − SHIP_PIX_W)/2, which is 303 with defaults.
- `sprite_y` = SHIP_Y.
- `velocity` = 0, `pos_update` = 0.
- Filter taps = 0; state = IDLE.

Filter:
- 4-tap moving average over accepted samples.
- Each cycle with `tilt_valid`=1 shifts `tilt_x` in.
- Sum is TILT_W+2 bits signed; average = sum >>> 2 (arithmetic shift).

Velocity:
- v = avg >>> TILT_SHIFT.
- Saturate v to [−MAX_SPEED, +MAX_SPEED].
- Deadzone step applies only when it is compiled in (see Configuration).

State machine:
- IDLE: on `frame`=1 && `en`=1, go to CALC. If `en`=0, `frame` is ignored.
- CALC: register the saturated v into `velocity`; go to MOVE.
- MOVE:
  - nx = sprite_x + velocity, computed signed at SCREEN_CORDW+1 bits.
  - If nx < 0, write 0. If nx > H_RES − SHIP_PIX_W, write that limit. Otherwise write nx.
  - Assert `pos_update`; go to IDLE.
- The X position never wraps.

Boundary rules:
- A `frame` pulse arriving in CALC or MOVE is ignored.
- Samples are accepted in every state.
- A `tilt_valid` in the same cycle as `frame` is included in that frame's computation, because CALC reads the updated taps.
- `rst` in any state returns all outputs and taps to their reset values on the next edge. No update is in flight afterwards.
- `sprite_y` is constant at SHIP_Y.

## Timing
- `frame` sampled high in IDLE at edge N → state CALC after N.
- `velocity` is valid after edge N+1.
- `sprite_x` is updated and `pos_update`=1 after edge N+2; `pos_update` drops after N+3.
- Outputs are registered and stable for the rest of the frame.
- Filter latency is 1 cycle per sample.

## Configuration
- `SHIP_MOTION_DEADZONE_EN` defined: after saturation, |v| ≤ DEADZONE → v = 0. This suppresses drift from a level board.
- Undefined: no deadzone; every nonzero saturated v moves the ship.

## Structure
- Package `ship_pkg` holds:
  - the state enum (IDLE, CALC, MOVE);
  - the shared screen constants H_RES, V_RES and SCREEN_CORDW, so `Top` and the sprite modules use the same values.
- Sub-module `tilt_filter` holds the 4-tap shift register and sum, with outputs `avg` and `avg_valid`.

## Test plan
- Reset and idle: after `rst` → `sprite_x`=303, `sprite_y`=300, `velocity`=0; with no samples, a `frame` leaves `sprite_x`=303 and still pulses `pos_update` at N+2.
- Saturated motion: four samples of `tilt_x`=+1024, then `frame` → `velocity`=+8 after N+1, `sprite_x`=311 after N+2.
- Left wall: `tilt_x`=−4096 held over 40 frames → `sprite_x` falls by 8 per frame to 0 and stays at 0 with no wrap; right wall with +4096 → `sprite_x` settles at 606.
- Deadzone: `tilt_x`=+64 repeated (v=2), then `frame` → macro defined: `sprite_x` unchanged; macro undefined: `sprite_x` +2.
- Pause and simultaneity: `en`=0 with `frame` → no `pos_update` and no change. With three +1024 samples already in the taps, a fourth +1024 sample coinciding with `frame` → `velocity`=+8; with 0 in place of that fourth sample → 768>>>5=24 saturates to `velocity`=+8. Both show the same-cycle sample is included.
- Mid-update reset: assert `rst` in the cycle the state is CALC → no `pos_update`; `sprite_x`=303; taps cleared (the next `frame` gives `velocity`=0).
